// File: rtl/minesweeper_pkg.sv
// Shared constants and types for the minesweeper board blocks.
//   Cell codes: 0..8 revealed neighbour count, 9 hidden safe, 10 hidden bomb.
//   Board is BOARD_W x BOARD_W, row-major, id = BOARD_W*row + col.
package minesweeper_pkg;

  localparam int unsigned BOARD_W     = 5;
  localparam int unsigned CELLS       = BOARD_W * BOARD_W;
  localparam int unsigned ID_W        = 5;
  localparam int unsigned HIDDEN_CODE = 9;
  localparam int unsigned BOMB_CODE   = 10;

  // Feedback taps of the 8-bit Fibonacci LFSR: l[7]^l[5]^l[4]^l[3]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PLACE,
    ST_FINISH
  } placer_state_e;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, shift-left, period 255 for any non-zero seed.
//   clk, reset_n : clock, synchronous active-low reset
//   load, seed   : load seed (priority over advance)
//   advance      : step one position
//   q            : current register value
module lfsr8
  import minesweeper_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= 8'h00;
    end else if (load) begin
      q <= seed;
    end else if (advance) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/board_mine_placer.sv
// Builds a fresh board through the memory's single write port: clears all
// cells to the hidden code, then places NUM_BOMBS bombs at distinct
// pseudo-random cells, never on the player's first-clicked cell.
//   clk, reset_n       : clock, synchronous active-low reset
//   start              : one-cycle build request (ignored while busy)
//   seed_in, safe_id   : LFSR seed and protected cell, sampled on start
//   busy, done         : build in progress / one-cycle completion pulse
//   mem_wEn/addr/data  : registered write port to the board memory
module board_mine_placer
  import minesweeper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned CELLS         = minesweeper_pkg::CELLS,
  parameter int unsigned NUM_BOMBS     = 5,
  parameter int unsigned HIDDEN_CODE   = minesweeper_pkg::HIDDEN_CODE,
  parameter int unsigned BOMB_CODE     = minesweeper_pkg::BOMB_CODE,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [7:0]               seed_in,
  input  logic [4:0]               safe_id,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data
);

  localparam int unsigned OCC_W = 2 ** ID_W;
  localparam int unsigned CNT_W = $clog2(CELLS + 1);

  if (NUM_BOMBS > CELLS - 1) begin : g_bad_num_bombs
    $error("board_mine_placer: NUM_BOMBS must not exceed CELLS-1");
  end

  placer_state_e             state_q, state_d;
  logic [ID_W-1:0]           safe_q, safe_d;
  logic [ID_W-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [OCC_W-1:0]          occ_q, occ_d;
  logic                      busy_d, done_d, wen_d;
  logic [ADDRESS_WIDTH-1:0]  addr_d;
  logic [DATA_WIDTH-1:0]     data_d;

  logic                      lfsr_load, lfsr_adv;
  logic [7:0]                lfsr_seed, lfsr_q;
  logic [ID_W-1:0]           cand;
  logic                      accept;

  // Zero is the LFSR lock-up state, so it is replaced by the fixed seed
  assign lfsr_seed = (seed_in == 8'h00) ? LFSR_SEED : seed_in;

  lfsr8 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .advance (lfsr_adv),
    .q       (lfsr_q)
  );

  // Candidate from the low bits; a locked-up (all-zero) LFSR never places
  assign cand   = lfsr_q[ID_W-1:0];
  assign accept = (|lfsr_q) && (32'(cand) < CELLS) && (cand != safe_q) && !occ_q[cand];

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      safe_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_wEn  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state_q  <= state_d;
      safe_q   <= safe_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      busy     <= busy_d;
      done     <= done_d;
      mem_wEn  <= wen_d;
      mem_addr <= addr_d;
      mem_data <= data_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    safe_d    = safe_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    occ_d     = occ_q;
    busy_d    = busy;
    done_d    = 1'b0;
    wen_d     = 1'b0;
    addr_d    = mem_addr;
    data_d    = mem_data;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          safe_d    = safe_id;
          lfsr_load = 1'b1;
          occ_d     = '0;
          cnt_d     = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        wen_d  = 1'b1;
        addr_d = ADDRESS_WIDTH'(idx_q);
        data_d = DATA_WIDTH'(HIDDEN_CODE);
        if (idx_q == ID_W'(CELLS - 1)) begin
          idx_d   = '0;
          state_d = (NUM_BOMBS == 0) ? ST_FINISH : ST_PLACE;
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end

      ST_PLACE: begin
        lfsr_adv = 1'b1;
        if (accept) begin
          wen_d       = 1'b1;
          addr_d      = ADDRESS_WIDTH'(cand);
          data_d      = DATA_WIDTH'(BOMB_CODE);
          occ_d[cand] = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(NUM_BOMBS)) begin
            state_d = ST_FINISH;
          end
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_board_mine_placer.sv
// Self-checking bench for board_mine_placer: table-driven builds, random
// seeds on corner safe cells, and hand-written multi-cycle sequences.
module tb_board_mine_placer;

  localparam int NB       = 5;
  localparam int NCELL    = 25;
  localparam int SPAN_MAX = 25 + 255 * NB + 1;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        start    = 1'b0;
  logic [7:0]  seed_in  = 8'h00;
  logic [4:0]  safe_id  = 5'd0;
  logic        busy, done, mem_wEn;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;

  board_mine_placer #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (12)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .seed_in  (seed_in),
    .safe_id  (safe_id),
    .busy     (busy),
    .done     (done),
    .mem_wEn  (mem_wEn),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  int n_checks    = 0;
  int n_fail      = 0;
  int cyc         = 0;
  int start_cyc   = 0;
  int busy_cycles = 0;
  int done_cycles = 0;
  int got_addr[$];
  int got_data[$];
  int got_rel[$];
  int mem[NCELL];
  int exp_bombs[$];
  int exp_place   = 0;

  // Board memory stand-in and bus monitor; memory writes on negedge
  always @(negedge clk) begin
    cyc++;
    if (mem_wEn) begin
      got_addr.push_back(int'(mem_addr));
      got_data.push_back(int'(mem_data));
      got_rel.push_back(cyc - start_cyc);
      if (int'(mem_addr) < NCELL) mem[int'(mem_addr)] = int'(mem_data);
    end
    if (busy) busy_cycles++;
    if (done) done_cycles++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: bomb list and PLACE-cycle count straight from the placement rules
  task automatic model(input logic [7:0] seed, input int safe);
    logic [7:0] l;
    bit         taken[NCELL];
    int         c;
    l = (seed == 8'h00) ? 8'hA5 : seed;
    exp_bombs.delete();
    exp_place = 0;
    for (int i = 0; i < NCELL; i++) taken[i] = 1'b0;
    while (exp_bombs.size() < NB && exp_place < 5000) begin
      c = int'(l[4:0]);
      exp_place++;
      if (c < NCELL && c != safe) begin
        if (!taken[c]) begin
          taken[c] = 1'b1;
          exp_bombs.push_back(c);
        end
      end
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endtask

  function automatic bit is_nbr(input int a, input int b);
    int dr, dc;
    dr = a / 5 - b / 5;
    dc = a % 5 - b % 5;
    return (a != b) && dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1;
  endfunction

  function automatic int nbr_mem(input int id);
    int n = 0;
    for (int i = 0; i < NCELL; i++) if (is_nbr(i, id) && mem[i] == 10) n++;
    return n;
  endfunction

  function automatic int nbr_model(input int id);
    int n = 0;
    foreach (exp_bombs[i]) if (is_nbr(exp_bombs[i], id)) n++;
    return n;
  endfunction

  task automatic launch(input logic [7:0] seed, input int safe);
    got_addr.delete();
    got_data.delete();
    got_rel.delete();
    busy_cycles = 0;
    done_cycles = 0;
    for (int i = 0; i < NCELL; i++) mem[i] = -1;
    seed_in   = seed;
    safe_id   = 5'(safe);
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cycles == 0 && k < 2000) begin
      tick();
      k++;
    end
    check({tag, " done_seen"}, int'(done_cycles != 0), 1);
    tick();
    tick();
  endtask

  task automatic verify(input logic [7:0] seed, input int safe, input string tag);
    int ok, at_safe, n9, n10;
    model(seed, safe);
    check({tag, " nwrites"}, got_addr.size(), 25 + NB);
    if (got_addr.size() >= 25 + NB && exp_bombs.size() == NB) begin
      ok = 1;
      for (int k = 0; k < 25; k++) if (got_addr[k] != k || got_data[k] != 9) ok = 0;
      check({tag, " clear_seq"}, ok, 1);
      check({tag, " clear_consecutive"}, got_rel[24] - got_rel[0], 24);
      ok = 0;
      at_safe = 0;
      for (int i = 0; i < NB; i++) begin
        if (got_addr[25 + i] == exp_bombs[i] && got_data[25 + i] == 10) ok++;
        if (got_addr[25 + i] == safe) at_safe++;
      end
      check({tag, " bombs_match"}, ok, NB);
      check({tag, " bomb_at_safe"}, at_safe, 0);
    end
    check({tag, " busy_span"}, busy_cycles, 25 + exp_place + 1);
    check({tag, " span_bound"}, int'(busy_cycles <= SPAN_MAX), 1);
    check({tag, " done_width"}, done_cycles, 1);
    check({tag, " busy_after"}, int'(busy), 0);
    n9 = 0;
    n10 = 0;
    for (int i = 0; i < NCELL; i++) begin
      if (mem[i] == 9) n9++;
      if (mem[i] == 10) n10++;
    end
    check({tag, " mem_bombs"}, n10, 5);
    check({tag, " mem_hidden"}, n9, 20);
  endtask

  typedef struct {
    logic [7:0] seed;
    int         safe;
    int         span;
    int         first_bomb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int sa[$];
    int sr[$];
    int ok;
    int k;
    logic [7:0] s;

    // Row 0 expectations worked out by hand from the LFSR rule
    vecs[0] = '{8'h3C, 12, 37, 19};
    vecs[1] = '{8'h01, 0, 0, 0};
    vecs[2] = '{8'hFF, 24, 0, 0};
    vecs[3] = '{8'h80, 5, 0, 0};
    vecs[4] = '{8'h00, 12, 0, 0};
    for (int i = 1; i < 5; i++) begin
      model(vecs[i].seed, vecs[i].safe);
      vecs[i].span       = 25 + exp_place + 1;
      vecs[i].first_bomb = exp_bombs[0];
    end

    // Reset state
    repeat (3) tick();
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst wen", int'(mem_wEn), 0);
    check("rst addr", int'(mem_addr), 0);
    check("rst data", int'(mem_data), 0);
    reset_n = 1'b1;
    tick();

    // Table-driven builds
    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].seed, vecs[i].safe);
      wait_done($sformatf("vec%0d", i));
      verify(vecs[i].seed, vecs[i].safe, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_span", i), busy_cycles, vecs[i].span);
      if (got_addr.size() > 25) check($sformatf("vec%0d tbl_first", i), got_addr[25], vecs[i].first_bomb);
      check($sformatf("vec%0d nbr_safe", i), nbr_mem(vecs[i].safe), nbr_model(vecs[i].safe));
      if (i == 0) check("vec0 nbr12_hand", nbr_mem(12), 2);
    end

    // Zero seed behaves exactly like the substitute seed
    launch(8'h00, 3);
    wait_done("zs0");
    verify(8'h00, 3, "zs0");
    sa = got_addr;
    sr = got_rel;
    launch(8'hA5, 3);
    wait_done("zsA5");
    verify(8'hA5, 3, "zsA5");
    ok = int'(sa.size() == got_addr.size());
    if (ok == 1) foreach (sa[i]) if (sa[i] != got_addr[i] || sr[i] != got_rel[i]) ok = 0;
    check("zero_seed identical", ok, 1);

    // Start while busy is ignored
    launch(8'h3C, 12);
    k = 0;
    while (got_addr.size() < 10 && k < 200) begin
      tick();
      k++;
    end
    seed_in = 8'h55;
    safe_id = 5'd7;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_done("busy_start");
    verify(8'h3C, 12, "busy_start");

    // Reset in PLACE after two bombs
    launch(8'h77, 7);
    k = 0;
    while (got_addr.size() < 27 && k < 2000) begin
      tick();
      k++;
    end
    check("midrst reached", got_addr.size(), 27);
    reset_n = 1'b0;
    tick();
    check("midrst wen", int'(mem_wEn), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst no_more_writes", got_addr.size(), 27);
    reset_n = 1'b1;
    tick();
    launch(8'h77, 7);
    wait_done("after_rst");
    verify(8'h77, 7, "after_rst");

    // Corner safe cells with random seeds
    for (int i = 0; i < 40; i++) begin
      s = 8'($urandom_range(0, 255));
      launch(s, (i < 20) ? 0 : 24);
      wait_done($sformatf("rnd%0d", i));
      verify(s, (i < 20) ? 0 : 24, $sformatf("rnd%0d", i));
    end

    // A few fully random cases
    for (int i = 0; i < 8; i++) begin
      s = 8'($urandom_range(0, 255));
      k = int'($urandom_range(0, 24));
      launch(s, k);
      wait_done($sformatf("any%0d", i));
      verify(s, k, $sformatf("any%0d", i));
      check($sformatf("any%0d nbr_safe", i), nbr_mem(k), nbr_model(k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
